// File: rtl/alu_stage_if.sv
// alu_stage_if: handshake and data bundle between an operation producer and alu_stage.
//   in_valid/in_ready  : operation handshake (producer -> stage)
//   op, opa, opb       : opcode and operands, sampled when in_valid && in_ready
//   out_valid/out_ready: result handshake (stage -> consumer)
//   result, carry, zero: registered result and flags
//   busy               : stage is not idle
// The slave modport is the ALU stage; the master modport is the producer/consumer side.
interface alu_stage_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         busy;

    modport master (
        output in_valid, op, opa, opb, out_ready,
        input  in_ready, out_valid, result, carry, zero, busy
    );

    modport slave (
        input  in_valid, op, opa, opb, out_ready,
        output in_ready, out_valid, result, carry, zero, busy
    );
endinterface

// File: rtl/alu_stage.sv
// alu_stage: single-issue ALU with registered result/flags and a valid/ready
// handshake on both sides. ADD/SUB/AND/OR/XOR/SHL1/SHR1 complete in one cycle;
// MUL is an unsigned shift-add taking one multiplier bit per cycle.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_stage_if.slave (operation in, result/flags out, busy)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an operation, in_ready = 1
// MUL   | shift-add multiply in progress, W cycles
// DONE  | result presented, out_valid = 1, held until out_ready
module alu_stage #(
    parameter int W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_stage_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL1 = 3'b101;
    localparam logic [2:0] OP_SHR1 = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [W-1:0]   result_q;
    logic           carry_q;
    logic [W-1:0]   mcand_q;
    logic [2*W-1:0] prod_q;
    logic [CW-1:0]  cnt_q;

    logic           in_ready_c;
    logic           out_valid_c;
    logic           busy_c;
    logic           transfer;
    logic           mul_last;

    logic [W:0]     alu_wide;
    logic [W-1:0]   alu_res;
    logic           alu_carry;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] prod_next;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b1;
        case (state)
            S_IDLE: begin
                // Gated with rst_n so the stage never advertises readiness during reset.
                in_ready_c = rst_n;
                busy_c     = 1'b0;
                if (bus.in_valid) begin
                    state_next = (bus.op == OP_MUL) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (cnt_q == CW'(1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign transfer = bus.in_valid && in_ready_c;
    assign mul_last = (state == S_MUL) && (cnt_q == CW'(1));

    // ---------------- single-cycle ALU ----------------
    // Everything is computed at W+1 bits; bit W is the carry/borrow/shifted-out bit.
    always_comb begin
        alu_wide = '0;
        case (bus.op)
            OP_ADD:  alu_wide = {1'b0, bus.opa} + {1'b0, bus.opb};
            OP_SUB:  alu_wide = {1'b0, bus.opa} - {1'b0, bus.opb};
            OP_AND:  alu_wide = {1'b0, bus.opa & bus.opb};
            OP_OR:   alu_wide = {1'b0, bus.opa | bus.opb};
            OP_XOR:  alu_wide = {1'b0, bus.opa ^ bus.opb};
            OP_SHL1: alu_wide = {bus.opa, 1'b0};
            OP_SHR1: alu_wide = {bus.opa[0], 1'b0, bus.opa[W-1:1]};
            default: alu_wide = '0;
        endcase
    end

    assign alu_res   = alu_wide[W-1:0];
    assign alu_carry = alu_wide[W];

    // ---------------- shift-add multiplier step ----------------
    // prod_q holds {partial_high, remaining_multiplier_bits}; each step adds the
    // multiplicand into the high half when the current multiplier LSB is set,
    // then shifts the whole pair right by one.
    assign mul_sum   = {1'b0, prod_q[2*W-1:W]}
                     + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
    assign prod_next = {mul_sum, prod_q[W-1:1]};

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else if (transfer) begin
            if (bus.op == OP_MUL) begin
                mcand_q <= bus.opa;
                prod_q  <= {{W{1'b0}}, bus.opb};
                cnt_q   <= CW'(W);
            end else begin
                result_q <= alu_res;
                carry_q  <= alu_carry;
            end
        end else if (state == S_MUL) begin
            prod_q <= prod_next;
            cnt_q  <= cnt_q - CW'(1);
            if (mul_last) begin
                result_q <= prod_next[W-1:0];
                carry_q  <= |prod_next[2*W-1:W];
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = (result_q == '0);
endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: self-checking bench for alu_stage (W = 8). Directed scenarios plus
// randomized operations compared against an arithmetic reference model.
module tb_alu_stage;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_stage_if #(.W(W)) bus ();

    alu_stage #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: returns {carry, result} from plain integer arithmetic.
    function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned ua, ub, r, p;
        bit c;
        ua = a;
        ub = b;
        r  = 0;
        c  = 0;
        case (o)
            3'd0: begin r = (ua + ub) % 256; c = (ua + ub) > 255; end
            3'd1: begin r = (ua + 256 - ub) % 256; c = ua < ub; end
            3'd2: begin r = ua & ub; c = 0; end
            3'd3: begin r = ua | ub; c = 0; end
            3'd4: begin r = ua ^ ub; c = 0; end
            3'd5: begin r = (ua * 2) % 256; c = ua >= 128; end
            3'd6: begin r = ua / 2; c = (ua % 2) == 1; end
            default: begin p = ua * ub; r = p % 256; c = (p / 256) != 0; end
        endcase
        return {c, r[W-1:0]};
    endfunction

    // Issues one operation and waits (bounded) for out_valid. Returns observations only.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int pulse_at, output int lat, output int busy_cycles,
                         output bit timeout, output bit ready_seen);
        @(negedge clk);
        ready_seen   = bus.in_ready;
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.opa      = a;
        bus.opb      = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op       = 3'($urandom_range(0, 7));
        bus.opa      = 8'($urandom);
        bus.opb      = 8'($urandom);
        lat          = 0;
        busy_cycles  = 0;
        timeout      = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            lat = k;
            if (bus.out_valid) begin
                timeout = 1'b0;
                break;
            end
            if (bus.busy) busy_cycles++;
            if (k == pulse_at) begin
                bus.in_valid = 1'b1;
                bus.op       = 3'b000;
                bus.opa      = 8'hFF;
                bus.opb      = 8'hFF;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op  = 3'b000;
        bus.opa = '0;
        bus.opb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.carry, bus.zero, bus.result} !== {5'b00001, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b ov=%b busy=%b c=%b z=%b r=%h, want 0 0 0 0 1 00",
                     bus.in_ready, bus.out_valid, bus.busy, bus.carry, bus.zero, bus.result);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_add;
        int lat, bc;
        bit to, rs;
        bus.out_ready = 1'b1;
        do_op(3'd0, 8'hF0, 8'h20, 0, lat, bc, to, rs);
        checks++;
        if ({to, lat, bus.result, bus.carry, bus.zero} !== {1'b0, 32'd1, 8'h10, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_f0_20: got to=%b lat=%0d r=%h c=%b z=%b, want to=0 lat=1 r=10 c=1 z=0",
                     to, lat, bus.result, bus.carry, bus.zero);
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b010) begin
            errors++;
            $display("FAIL add_back_to_idle: got busy/rdy/ov=%b%b%b want 010",
                     bus.busy, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_sub;
        int lat, bc;
        bit to, rs;
        bus.out_ready = 1'b1;
        do_op(3'd1, 8'h05, 8'h05, 0, lat, bc, to, rs);
        checks++;
        if ({to, bus.result, bus.carry, bus.zero} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sub_equal: got to=%b r=%h c=%b z=%b want to=0 r=00 c=0 z=1",
                     to, bus.result, bus.carry, bus.zero);
        end
        do_op(3'd1, 8'h03, 8'h05, 0, lat, bc, to, rs);
        checks++;
        if ({to, bus.result, bus.carry, bus.zero} !== {1'b0, 8'hFE, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow: got to=%b r=%h c=%b z=%b want to=0 r=fe c=1 z=0",
                     to, bus.result, bus.carry, bus.zero);
        end
    endtask

    task automatic test_mul;
        int lat, bc;
        bit to, rs;
        bus.out_ready = 1'b1;
        do_op(3'd7, 8'h10, 8'h11, 3, lat, bc, to, rs);
        checks++;
        if ({to, lat, bc} !== {1'b0, 32'd9, 32'd8}) begin
            errors++;
            $display("FAIL mul_timing: got to=%b lat=%0d busy_cycles=%0d want to=0 lat=9 busy_cycles=8",
                     to, lat, bc);
        end
        checks++;
        if ({bus.result, bus.carry, bus.zero} !== {8'h10, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mul_10x11: got r=%h c=%b z=%b want r=10 c=1 z=0",
                     bus.result, bus.carry, bus.zero);
        end
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
            errors++;
            $display("FAIL mul_pulse_ignored: got ov/rdy/busy=%b%b%b want 010",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_backpressure;
        int lat, bc;
        bit to, rs;
        bus.out_ready = 1'b0;
        do_op(3'd5, 8'h81, 8'h00, 0, lat, bc, to, rs);
        checks++;
        if ({to, lat} !== {1'b0, 32'd1}) begin
            errors++;
            $display("FAIL shl1_latency: got to=%b lat=%0d want to=0 lat=1", to, lat);
        end
        // A new request during the stall must not disturb the held result.
        bus.in_valid = 1'b1;
        bus.op       = 3'b000;
        bus.opa      = 8'h11;
        bus.opb      = 8'h22;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.carry, bus.result} !== {3'b101, 8'h02}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got ov=%b rdy=%b c=%b r=%h want ov=1 rdy=0 c=1 r=02",
                         i, bus.out_valid, bus.in_ready, bus.carry, bus.result);
            end
            if (i < 4) @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b010) begin
            errors++;
            $display("FAIL backpressure_release: got busy/rdy/ov=%b%b%b want 010",
                     bus.busy, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_out_ready_idle;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) begin
                errors++;
                $display("FAIL out_ready_idle: got ov/busy/rdy=%b%b%b want 001",
                         bus.out_valid, bus.busy, bus.in_ready);
            end
        end
    endtask

    task automatic test_reset_mid_mul;
        int lat, bc;
        bit to, rs;
        int seen_valid;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 3'd7;
        bus.opa      = 8'hFF;
        bus.opb      = 8'hFF;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.result, bus.zero, bus.busy, bus.in_ready} !== {1'b0, 8'h00, 3'b100}) begin
            errors++;
            $display("FAIL reset_mid_mul: got ov=%b r=%h z=%b busy=%b rdy=%b want ov=0 r=00 z=1 busy=0 rdy=0",
                     bus.out_valid, bus.result, bus.zero, bus.busy, bus.in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_mul_ready: got %b want 1", bus.in_ready);
        end
        seen_valid = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid++;
        end
        checks++;
        if (seen_valid !== 0) begin
            errors++;
            $display("FAIL reset_mid_mul_no_stale: got %0d valid cycles want 0", seen_valid);
        end
        do_op(3'd2, 8'hF0, 8'h3C, 0, lat, bc, to, rs);
        checks++;
        if ({to, lat, bus.result, bus.carry} !== {1'b0, 32'd1, 8'h30, 1'b0}) begin
            errors++;
            $display("FAIL and_after_reset: got to=%b lat=%0d r=%h c=%b want to=0 lat=1 r=30 c=0",
                     to, lat, bus.result, bus.carry);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [2:0]   o;
        logic [W-1:0] a, b;
        logic [W:0]   exp;
        int lat, bc, stall, exp_lat;
        bit to, rs;
        logic [2:0]   dir_op [4] = '{3'd0, 3'd6, 3'd7, 3'd7};
        logic [W-1:0] dir_a  [4] = '{8'hFF, 8'h01, 8'hFF, 8'h0F};
        logic [W-1:0] dir_b  [4] = '{8'h01, 8'h00, 8'hFF, 8'h0F};
        for (int n = 0; n < 44; n++) begin
            if (n < 4) begin
                o = dir_op[n];
                a = dir_a[n];
                b = dir_b[n];
                stall = 0;
            end else begin
                o = 3'($urandom_range(0, 7));
                a = 8'($urandom);
                b = 8'($urandom);
                stall = $urandom_range(0, 3);
            end
            exp     = model(o, a, b);
            exp_lat = (o == 3'd7) ? W + 1 : 1;
            bus.out_ready = (stall == 0);
            do_op(o, a, b, 0, lat, bc, to, rs);
            checks++;
            if ({to, rs, lat, bus.result, bus.carry, bus.zero} !==
                {1'b0, 1'b1, exp_lat, exp[W-1:0], exp[W], exp[W-1:0] == 8'h00}) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got to=%b rdy=%b lat=%0d r=%h c=%b z=%b want lat=%0d r=%h c=%b z=%b",
                         n, o, a, b, to, rs, lat, bus.result, bus.carry, bus.zero,
                         exp_lat, exp[W-1:0], exp[W], exp[W-1:0] == 8'h00);
            end
            repeat (stall) begin
                @(negedge clk);
                checks++;
                if ({bus.out_valid, bus.carry, bus.result} !== {1'b1, exp}) begin
                    errors++;
                    $display("FAIL random_hold[%0d]: got ov=%b c=%b r=%h want ov=1 c=%b r=%h",
                             n, bus.out_valid, bus.carry, bus.result, exp[W], exp[W-1:0]);
                end
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL random_drain[%0d]: got ov=%b want 0", n, bus.out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_backpressure();
        test_out_ready_idle();
        test_reset_mid_mul();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
